// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin select arbiter.
// The requester count and select width are fixed by the 4:1 datapath.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // OR-reduction encoder; only meaningful for one-hot or all-zero input.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: first set request at or after start_i (with wrap),
// or the lowest set index when fixed_i is high.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] start_i,
    input  logic             fixed_i,
    output logic             valid_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] base;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    assign base = fixed_i ? '0 : start_i;

    // Rotate so that position 0 of rot is the first candidate; index math wraps mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req_i[base + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SEL_W'(k);
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = base + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Arbitrates four requesters onto one shared 4:1 data-select path; each grant
// lasts until the owner drops its request or HOLD_MAX cycles have elapsed.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX  = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] Req,
    input  logic [N_REQ-1:0] D,
    output logic [N_REQ-1:0] Grant,
    output logic             Sel1,
    output logic             Sel0,
    output logic             Busy,
    output logic             Result
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [SEL_W-1:0] owner;
    logic             release_now;
    logic [N_REQ-1:0] pick_req;
    logic [SEL_W-1:0] pick_start;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

    assign owner       = onehot_to_idx(grant_q);
    assign release_now = (state_q == GRANT) && (!Req[owner] || (cnt_q == CNT_LAST));

    // At a release the owner is masked so another pending requester wins first.
    assign pick_req   = (state_q == GRANT) ? (Req & ~grant_q) : Req;
    assign pick_start = last_q + 2'd1;

    rr_pick4 u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .fixed_i (FIXED_PRI != 0),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= GRANT;
                        grant_q <= N_REQ'(1) << pick_idx;
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        last_q  <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (pick_valid) begin
                        grant_q <= N_REQ'(1) << pick_idx;
                        sel_q   <= pick_idx;
                        cnt_q   <= '0;
                        last_q  <= pick_idx;
                    end else if (Req[owner]) begin
                        // Timeout with nobody else waiting: owner keeps the path.
                        cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Grant  = grant_q;
    assign Sel1   = sel_q[1];
    assign Sel0   = sel_q[0];
    assign Busy   = busy_q;
    assign Result = busy_q ? D[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Vector-table and scoreboard bench for mux4_rr_arbiter across several
// HOLD_MAX / FIXED_PRI configurations, plus a model-driven random phase.
module tb_mux4_rr_arbiter;

    localparam int N_DUT = 5;
    localparam int HM [N_DUT] = '{8, 2, 4, 3, 1};
    localparam int FP [N_DUT] = '{0, 0, 0, 1, 0};

    typedef struct {
        int         inst;
        bit         rst;
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] grant;
        logic [1:0] sel;
        bit         busy;
        bit         result;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_s    [N_DUT];
    logic [3:0] req_s    [N_DUT];
    logic [3:0] d_s      [N_DUT];
    logic [3:0] grant_w  [N_DUT];
    logic       sel1_w   [N_DUT];
    logic       sel0_w   [N_DUT];
    logic       busy_w   [N_DUT];
    logic       result_w [N_DUT];

    vec_t vecs [$];
    vec_t sb_q [$];
    int   checks = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N_DUT; gi++) begin : g_dut
            mux4_rr_arbiter #(.HOLD_MAX(HM[gi]), .FIXED_PRI(FP[gi])) u_dut (
                .CLK    (clk),
                .RST    (rst_s[gi]),
                .Req    (req_s[gi]),
                .D      (d_s[gi]),
                .Grant  (grant_w[gi]),
                .Sel1   (sel1_w[gi]),
                .Sel0   (sel0_w[gi]),
                .Busy   (busy_w[gi]),
                .Result (result_w[gi])
            );
        end
    endgenerate

    function automatic void add(input int inst, input bit rst, input logic [3:0] req,
                                input logic [3:0] d, input logic [3:0] grant,
                                input logic [1:0] sel, input bit busy, input bit result,
                                input string name);
        vec_t v;
        v.inst = inst; v.rst = rst; v.req = req; v.d = d;
        v.grant = grant; v.sel = sel; v.busy = busy; v.result = result; v.name = name;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus at the falling edge, compare at the next falling edge.
    task automatic run_vec(input vec_t v);
        vec_t       e;
        logic [7:0] act;
        logic [7:0] exp;
        rst_s[v.inst] = v.rst;
        req_s[v.inst] = v.req;
        d_s[v.inst]   = v.d;
        sb_q.push_back(v);
        @(negedge clk);
        e   = sb_q.pop_front();
        act = {grant_w[e.inst], sel1_w[e.inst], sel0_w[e.inst], busy_w[e.inst], result_w[e.inst]};
        exp = {e.grant, e.sel, e.busy, e.result};
        checks++;
        if (act !== exp) begin
            $display("FAIL %s (dut%0d): got grant=%b sel=%b%b busy=%b result=%b, want grant=%b sel=%b busy=%b result=%b",
                     e.name, e.inst, act[7:4], act[3], act[2], act[1], act[0],
                     e.grant, e.sel, e.busy, e.result);
        end else begin
            passed++;
            $display("ok   %s (dut%0d): grant=%b sel=%b busy=%b result=%b",
                     e.name, e.inst, e.grant, e.sel, e.busy, e.result);
        end
    endtask

    // Round-robin pick for the HOLD_MAX=2 instance: first set bit after last, with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 0; k < 4; k++) begin
            if (r[(last + 1 + k) % 4]) return (last + 1 + k) % 4;
        end
        return -1;
    endfunction

    task automatic rand_phase(input int n);
        bit         m_busy = 1'b0;
        int         m_sel = 0;
        int         m_cnt = 0;
        int         m_last = 3;
        int         p;
        logic [3:0] prev_req = 4'b0000;
        vec_t       v;
        for (int c = 0; c < n; c++) begin
            v.inst = 1;
            v.rst  = (c == 0) || ($urandom_range(0, 39) == 0);
            v.req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : prev_req;
            v.d    = 4'($urandom);
            prev_req = v.req;
            if (v.rst) begin
                m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_last = 3;
            end else if (!m_busy) begin
                p = rr_pick(v.req, m_last);
                if (p >= 0) begin
                    m_busy = 1'b1; m_sel = p; m_cnt = 0; m_last = p;
                end
            end else if (!v.req[m_sel] || m_cnt == 1) begin
                p = rr_pick(v.req & ~(4'(1) << m_sel), m_last);
                if (p >= 0) begin
                    m_sel = p; m_cnt = 0; m_last = p;
                end else if (v.req[m_sel]) begin
                    m_cnt = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_cnt++;
            end
            v.grant  = m_busy ? (4'(1) << m_sel) : 4'b0000;
            v.sel    = 2'(m_sel);
            v.busy   = m_busy;
            v.result = m_busy && v.d[m_sel];
            v.name   = $sformatf("rand_%0d", c);
            run_vec(v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            rst_s[i] = 1'b1; req_s[i] = 4'b0000; d_s[i] = 4'b0000;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) rst_s[i] = 1'b0;

        // Reset with all requests high, single requester, idle hold.
        add(0, 1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 0, 0, "rst_a");
        add(0, 1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 0, 0, "rst_b");
        add(0, 0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "single_grant");
        add(0, 0, 4'b0000, 4'b0100, 4'b0000, 2'b10, 0, 0, "single_drop");
        add(0, 0, 4'b0000, 4'b1111, 4'b0000, 2'b10, 0, 0, "idle_hold");
        // Reset mid-grant at count 2, then RR search restarts at index 0.
        add(0, 0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1, 0, "mid_cnt0");
        add(0, 0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "mid_cnt1");
        add(0, 0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1, 0, "mid_cnt2");
        add(0, 1, 4'b0100, 4'b1111, 4'b0000, 2'b00, 0, 0, "mid_rst");
        add(0, 0, 4'b1111, 4'b1111, 4'b0001, 2'b00, 1, 1, "post_rst_rr0");
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "post_rst_drop");

        // HOLD_MAX=2 rotation with all requesters held: two cycles each, no gap.
        for (int k = 0; k < 9; k++) begin
            int idx;
            idx = (k / 2) % 4;
            add(1, 0, 4'b1111, 4'b0101, 4'(1) << idx, 2'(idx), 1, (idx % 2) == 0,
                $sformatf("rr2_%0d", k));
        end
        add(1, 0, 4'b0000, 4'b0101, 4'b0000, 2'b00, 0, 0, "rr2_idle");

        // HOLD_MAX=4 timeout re-grant; a late Req[0] only takes over at the release edge.
        for (int k = 0; k < 6; k++) add(2, 0, 4'b1000, 4'b1000, 4'b1000, 2'b11, 1, 1, $sformatf("to_%0d", k));
        add(2, 0, 4'b1001, 4'b1000, 4'b1000, 2'b11, 1, 1, "to_wait_a");
        add(2, 0, 4'b1001, 4'b1000, 4'b1000, 2'b11, 1, 1, "to_wait_b");
        add(2, 0, 4'b1001, 4'b1000, 4'b0001, 2'b00, 1, 0, "to_handoff");
        add(2, 0, 4'b1001, 4'b1000, 4'b0001, 2'b00, 1, 0, "to_hold");
        add(2, 0, 4'b0000, 4'b1000, 4'b0000, 2'b00, 0, 0, "to_idle");

        // Fixed priority, HOLD_MAX=3: Req[0] wins each release, Req[3] waits.
        add(3, 0, 4'b1010, 4'b0011, 4'b0010, 2'b01, 1, 1, "fp_first");
        add(3, 0, 4'b1011, 4'b0011, 4'b0010, 2'b01, 1, 1, "fp_hold1");
        add(3, 0, 4'b1011, 4'b0011, 4'b0010, 2'b01, 1, 1, "fp_hold2");
        add(3, 0, 4'b1011, 4'b0011, 4'b0001, 2'b00, 1, 1, "fp_take0");
        add(3, 0, 4'b1011, 4'b0011, 4'b0001, 2'b00, 1, 1, "fp_keep0a");
        add(3, 0, 4'b1011, 4'b0011, 4'b0001, 2'b00, 1, 1, "fp_keep0b");
        add(3, 0, 4'b1010, 4'b0011, 4'b0010, 2'b01, 1, 1, "fp_back1");
        add(3, 0, 4'b0000, 4'b0011, 4'b0000, 2'b01, 0, 0, "fp_idle");

        // HOLD_MAX=1: rotate every cycle, lone requester re-granted every edge.
        for (int k = 0; k < 5; k++) begin
            add(4, 0, 4'b1111, 4'b1010, 4'(1) << (k % 4), 2'(k % 4), 1, (k % 2) == 1,
                $sformatf("h1_%0d", k));
        end
        add(4, 0, 4'b0100, 4'b1010, 4'b0100, 2'b10, 1, 0, "h1_only2a");
        add(4, 0, 4'b0100, 4'b1010, 4'b0100, 2'b10, 1, 0, "h1_only2b");
        add(4, 0, 4'b0000, 4'b1010, 4'b0000, 2'b10, 0, 0, "h1_idle");

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        rand_phase(120);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
